// File: rtl/game_pkg.sv
// Shared game types: health FSM state enum, life limit, icon helper.
// Used by health_ctrl and the health drawer top level.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALIVE,
    INVULN,
    DEAD
  } health_state_t;

  localparam int MAX_LIVES = 3;

  // Thermometer code for the life icons: bit i set when h > i.
  function automatic logic [2:0] therm(input logic [1:0] h);
    therm = {h > 2'd2, h > 2'd1, h > 2'd0};
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick from vsync: one-cycle pulse one clk after a 0->1 is sampled.
// Ports: clk, rst (sync, active-high), vsync in; tick out (registered).
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic tick
);

  logic vsync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      tick    <= 1'b0;
    end else begin
      vsync_q <= vsync;
      tick    <= vsync & ~vsync_q;
    end
  end

endmodule

// File: rtl/health_ctrl.sv
// Player health FSM: lives, post-hit invulnerability with icon blink.
// Ports: clk, rst (sync, active-high), game_en, start, hit, heal, vsync in;
// health, health_en (to drawer health_en), icon_en (to drawer en),
// invuln, game_over out, all registered.
// Macro HEALTH_HEAL_EN enables heal; otherwise heal is ignored.
module health_ctrl
  import game_pkg::*;
#(
  parameter int MAX_HEALTH    = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_en,
  input  logic       start,
  input  logic       hit,
  input  logic       heal,
  input  logic       vsync,
  output logic [1:0] health,
  output logic [2:0] health_en,
  output logic       icon_en,
  output logic       invuln,
  output logic       game_over
);

  localparam int FW = $clog2(INVULN_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [1:0]    HMAX  = 2'(MAX_HEALTH);
  localparam logic [FW-1:0] FLAST = FW'(INVULN_FRAMES - 1);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);

  health_state_t state;
  logic [FW-1:0] frame_cnt;
  logic [BW-1:0] blink_cnt;
  logic          tick;

`ifndef HEALTH_HEAL_EN
  logic unused_heal;
  assign unused_heal = heal;
`endif

  frame_tick_gen u_tick (
    .clk  (clk),
    .rst  (rst),
    .vsync(vsync),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      health    <= 2'd0;
      health_en <= 3'b000;
      icon_en   <= 1'b0;
      invuln    <= 1'b0;
      game_over <= 1'b0;
      frame_cnt <= '0;
      blink_cnt <= '0;
    end else if (start) begin
      // start is honoured even while gameplay is frozen
      state     <= ALIVE;
      health    <= HMAX;
      health_en <= therm(HMAX);
      icon_en   <= 1'b1;
      invuln    <= 1'b0;
      game_over <= 1'b0;
      frame_cnt <= '0;
      blink_cnt <= '0;
    end else if (game_en) begin
      unique case (state)
        ALIVE: begin
          if (hit) begin
            if (health > 2'd1) begin
              state     <= INVULN;
              health    <= health - 2'd1;
              health_en <= therm(health - 2'd1);
              invuln    <= 1'b1;
              icon_en   <= 1'b0;
              frame_cnt <= '0;
              blink_cnt <= '0;
            end else begin
              state     <= DEAD;
              health    <= 2'd0;
              health_en <= 3'b000;
              game_over <= 1'b1;
            end
`ifdef HEALTH_HEAL_EN
          end else if (heal && health < HMAX) begin
            health    <= health + 2'd1;
            health_en <= therm(health + 2'd1);
`endif
          end
        end
        INVULN: begin
`ifdef HEALTH_HEAL_EN
          if (heal && health < HMAX) begin
            health    <= health + 2'd1;
            health_en <= therm(health + 2'd1);
          end
`endif
          if (tick) begin
            // counter holds frames already elapsed; expire on the last one
            if (frame_cnt == FLAST) begin
              state     <= ALIVE;
              invuln    <= 1'b0;
              icon_en   <= 1'b1;
              frame_cnt <= '0;
              blink_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + FW'(1);
              if (blink_cnt == BLAST) begin
                blink_cnt <= '0;
                icon_en   <= ~icon_en;
              end else begin
                blink_cnt <= blink_cnt + BW'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_health_ctrl.sv
// Directed bench for health_ctrl: vector table plus multi-frame sequences.
// Expected values are hand-derived constants.
module tb_health_ctrl;

  logic       clk = 1'b0;
  logic       rst, game_en, start, hit, heal, vsync;
  logic [1:0] health;
  logic [2:0] health_en;
  logic       icon_en, invuln, game_over;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      nm;
    logic       st, ht, hl, ge;
    logic [1:0] h;
    logic [2:0] he;
    logic       ic, iv, go;
  } vec_t;

  vec_t v[8];

  always #5 clk = ~clk;

  health_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .game_en  (game_en),
    .start    (start),
    .hit      (hit),
    .heal     (heal),
    .vsync    (vsync),
    .health   (health),
    .health_en(health_en),
    .icon_en  (icon_en),
    .invuln   (invuln),
    .game_over(game_over)
  );

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [1:0] h,
                         input logic [2:0] he, input logic ic,
                         input logic iv, input logic go);
    chk({nm, ".health"}, {2'b0, health}, {2'b0, h});
    chk({nm, ".health_en"}, {1'b0, health_en}, {1'b0, he});
    chk({nm, ".icon_en"}, {3'b0, icon_en}, {3'b0, ic});
    chk({nm, ".invuln"}, {3'b0, invuln}, {3'b0, iv});
    chk({nm, ".game_over"}, {3'b0, game_over}, {3'b0, go});
  endtask

  // apply pulses for one clock; outputs are valid at the next negedge
  task automatic pulse(input logic s, input logic h, input logic hl);
    start = s; hit = h; heal = hl;
    @(negedge clk);
    start = 1'b0; hit = 1'b0; heal = 1'b0;
  endtask

  // one vsync rising edge; returns after the tick has been consumed
  task automatic frame();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    rst = 1'b1; game_en = 1'b1; start = 1'b0;
    hit = 1'b0; heal = 1'b0; vsync = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", 2'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_all("idle", 2'd0, 3'b000, 1'b0, 1'b0, 1'b0);

    v[0] = '{"start", 1, 0, 0, 1, 2'd3, 3'b111, 1, 0, 0};
    v[1] = '{"hit3", 0, 1, 0, 1, 2'd2, 3'b011, 0, 1, 0};
    v[2] = '{"hit_inv", 0, 1, 0, 1, 2'd2, 3'b011, 0, 1, 0};
`ifdef HEALTH_HEAL_EN
    v[3] = '{"heal_inv", 0, 0, 1, 1, 2'd3, 3'b111, 0, 1, 0};
    v[4] = '{"frz_hit", 0, 1, 0, 0, 2'd3, 3'b111, 0, 1, 0};
`else
    v[3] = '{"heal_inv", 0, 0, 1, 1, 2'd2, 3'b011, 0, 1, 0};
    v[4] = '{"frz_hit", 0, 1, 0, 0, 2'd2, 3'b011, 0, 1, 0};
`endif
    v[5] = '{"frz_start", 1, 0, 0, 0, 2'd3, 3'b111, 1, 0, 0};
    v[6] = '{"heal_sat", 0, 0, 1, 1, 2'd3, 3'b111, 1, 0, 0};
    v[7] = '{"idle_cyc", 0, 0, 0, 1, 2'd3, 3'b111, 1, 0, 0};

    foreach (v[i]) begin
      game_en = v[i].ge;
      pulse(v[i].st, v[i].ht, v[i].hl);
      chk_all(v[i].nm, v[i].h, v[i].he, v[i].ic, v[i].iv, v[i].go);
    end
    game_en = 1'b1;

    // blink and expiry, with an ignored hit at frame 10
    pulse(0, 1, 0);
    chk_all("hitA", 2'd2, 3'b011, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 120; k++) begin
      frame();
      if (k == 10) begin
        pulse(0, 1, 0);
        chk("hit10.health_en", {1'b0, health_en}, 4'h3);
      end
      if (k < 120) begin
        chk($sformatf("blink%0d", k), {3'b0, icon_en},
            {3'b0, 1'((k / 8) % 2)});
        if (k == 119) chk("inv119", {3'b0, invuln}, 4'h1);
      end
    end
    chk_all("expire", 2'd2, 3'b011, 1'b1, 1'b0, 1'b0);

    // freeze 50 frames during invulnerability
    pulse(0, 1, 0);
    chk_all("hitB", 2'd1, 3'b001, 1'b0, 1'b1, 1'b0);
    frames(60);
    game_en = 1'b0;
    frames(50);
    pulse(0, 1, 0);
    chk_all("frozen", 2'd1, 3'b001, icon_en, 1'b1, 1'b0);
    game_en = 1'b1;
    frames(59);
    chk("frz_rem59", {3'b0, invuln}, 4'h1);
    frame();
    chk_all("frz_exp", 2'd1, 3'b001, 1'b1, 1'b0, 1'b0);

`ifndef HEALTH_HEAL_EN
    pulse(0, 0, 1);
    chk_all("heal_off", 2'd1, 3'b001, 1'b1, 1'b0, 1'b0);
`endif

    // death and dead-state immunity
    pulse(0, 1, 0);
    chk_all("dead", 2'd0, 3'b000, 1'b1, 1'b0, 1'b1);
    pulse(0, 1, 0);
    chk_all("dead_hit", 2'd0, 3'b000, 1'b1, 1'b0, 1'b1);
    pulse(0, 0, 1);
    chk_all("dead_heal", 2'd0, 3'b000, 1'b1, 1'b0, 1'b1);
    pulse(1, 0, 0);
    chk_all("restart", 2'd3, 3'b111, 1'b1, 1'b0, 1'b0);

    // hit and heal together at health 2
    pulse(0, 1, 0);
    frames(120);
    chk("pre_hh", {2'b0, health}, 4'h2);
    pulse(0, 1, 1);
    chk_all("hit_heal", 2'd1, 3'b001, 1'b0, 1'b1, 1'b0);

    // rst aborts invulnerability
    frames(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all("rst_mid", 2'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    pulse(1, 0, 0);
    chk_all("start2", 2'd3, 3'b111, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
